logo_sprite_engine: RTL
=======================

Name: logo_sprite_engine

Overview:
- Parametrised sprite renderer for screen logos (title, game over, press start) with runtime position, display mode and per-frame animation.
- Takes pixel coordinates from the VGA controller and drives an external logo ROM; outputs a registered hit flag to the color mapper.
- Modes: static, blink, and slide-in from below the screen to a target position.

Parameters:
- LOGO_W, 96, logo width in pixels, also the ROM word width (1..256).
- LOGO_H, 16, logo height in rows (1..2^ADDR_W).
- ADDR_W, 4, ROM row address width.
- BLINK_FRAMES, 30, number of frames per visible/hidden phase in blink mode (>=1).
- SLIDE_STEP, 2, number of pixels moved up per frame in slide mode (>=1).
- SLIDE_START_Y, 480, Y position where a slide begins.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  vsync-rate level signal, synchronous to Clk; a frame tick is its rising edge.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- rom_addr  out  ADDR_W  ROM row address (combinational).
- rom_data  in  LOGO_W  ROM row, valid in the same cycle (async ROM); MSB is the leftmost pixel.
- start  in  1  one-cycle request that latches mode, target_x and target_y.
- hide  in  1  one-cycle request to blank the logo and return to IDLE.
- mode  in  2  display mode: 00 static, 01 blink, 10 slide, 11 reserved (treated as static).
- target_x  in  10  final left X.
- target_y  in  10  final top Y.
- busy  out  1  high while in SLIDE.
- done  out  1  one-cycle pulse when the logo reaches its final position.
- is_logo  out  1  registered pixel hit.

Behaviour:
- Reset values:
  - State is IDLE; pos_x and pos_y are 0.
  - visible=0, blink_cnt=0, frame_q=0.
  - is_logo=0, busy=0, done=0.
- Frame tick: frame_q is registered from frame_clk; tick = frame_clk & ~frame_q.
- States:
  - IDLE: logo hidden.
  - SLIDE: pos_y -= SLIDE_STEP on each tick. When pos_y - SLIDE_STEP <= target_y, pos_y = target_y and the next state is SHOW. done pulses in the cycle after the state enters SHOW. visible=1.
  - SHOW: position is fixed. Static: visible=1. Blink: on each tick blink_cnt increments; when it reaches BLINK_FRAMES-1 it resets to 0 and visible toggles.
- start (any state):
  - Latches mode and targets; pos_x = target_x.
  - Static or blink: pos_y = target_y, state goes to SHOW, visible=1, blink_cnt=0, done pulses next cycle.
  - Slide: pos_y = SLIDE_START_Y, state goes to SLIDE.
  - start during SLIDE restarts the slide.
- hide: state goes to IDLE and visible=0. hide wins over a simultaneous start.
- start and tick in the same cycle: start wins and no motion happens that cycle.
- If target_y >= SLIDE_START_Y in slide mode, the logo snaps to target on the first tick.
- Hit test (combinational, 11-bit arithmetic, no wrap):
  - Uses half-open bounds: pos_x <= DrawX < pos_x+LOGO_W and pos_y <= DrawY < pos_y+LOGO_H.
  - Inside the box: rom_addr = DrawY - pos_y (low ADDR_W bits). Outside: rom_addr = 0.
- is_logo <= hit & visible & (state != IDLE) & rom_data[LOGO_W-1-(DrawX-pos_x)]. Latency is 1 Clk from DrawX/DrawY.
- A logo partially past X=639 or Y=479 is clipped naturally. Rows and columns outside the box never read ROM bits.
- Asserting Reset_n low mid-slide clears everything immediately, including is_logo.

Test Plan:
1. Reset, then start with mode=00, target=(272,232). ROM row 0 = MSB set. Drive DrawX=272, DrawY=232 -> rom_addr=0 and is_logo=1 one cycle later; done pulses exactly once. DrawX=368 -> is_logo=0 (half-open bound).
2. Blink with BLINK_FRAMES=3. Start mode=01, then apply 6 frame ticks -> visible pattern over ticks is 1,1,0,0,0,1. Verify is_logo gated to match.
3. Slide with SLIDE_STEP=2, SLIDE_START_Y=480, target_y=470 -> pos_y goes 478,476,474,472,470 over 5 ticks, busy=1 throughout, then SHOW with busy=0 and a single done pulse. target_y=471 -> clamps to 471.
4. Start and hide in the same cycle during SHOW -> IDLE, is_logo=0 on all pixels. Start alone with a tick in the same cycle -> pos_y=SLIDE_START_Y, with no decrement that cycle.
5. Clipping: target=(600,470), LOGO_W=96. Sweep DrawX 599..639 -> hits only where ROM bits are set from X=600, no wrap into X<600. rom_addr stays 0 for DrawY=486.
6. Pull Reset_n low mid-slide, asynchronously to Clk -> is_logo, busy and done are 0 immediately. After release, state is IDLE with no spurious done.

Source files
------------

// File: rtl/logo_sprite_engine.sv
// logo_sprite_engine
//   Sprite renderer for screen logos (title, game over, press start). Holds a
//   runtime position, runs static / blink / slide-in modes off the frame tick,
//   drives an external async logo ROM by row, and produces a registered
//   per-pixel hit flag for the color mapper.
//
// Ports
//   Clk, Reset_n        system clock, async active-low reset
//   frame_clk           vsync-rate level; its rising edge is the frame tick
//   DrawX, DrawY        current pixel coordinate from the VGA controller
//   rom_addr / rom_data logo ROM row address (comb) / row data (same cycle,
//                       MSB = leftmost pixel)
//   start, hide         one-cycle requests (hide has priority)
//   mode                00 static, 01 blink, 10 slide, 11 static
//   target_x, target_y  final top-left position, latched on start
//   busy                high while sliding
//   done                one-cycle pulse when the final position is reached
//   is_logo             registered pixel hit, 1 Clk after DrawX/DrawY
module logo_sprite_engine #(
  parameter int LOGO_W        = 96,
  parameter int LOGO_H        = 16,
  parameter int ADDR_W        = 4,
  parameter int BLINK_FRAMES  = 30,
  parameter int SLIDE_STEP    = 2,
  parameter int SLIDE_START_Y = 480
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LOGO_W-1:0] rom_data,
  input  logic              start,
  input  logic              hide,
  input  logic [1:0]        mode,
  input  logic [9:0]        target_x,
  input  logic [9:0]        target_y,
  output logic              busy,
  output logic              done,
  output logic              is_logo
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, SLIDE, SHOW} state_t;

  state_t        state;
  logic [9:0]    pos_x, pos_y, ty_q;
  logic [1:0]    mode_q;
  logic [BW-1:0] blink_cnt;
  logic          visible, frame_q, tick;

  assign tick = frame_clk & ~frame_q;

  // Slide finishes once the next step would reach or pass the target.
  // Comparing against target+step avoids underflow on pos_y-step.
  logic [10:0] slide_lim;
  assign slide_lim = {1'b0, ty_q} + 11'(SLIDE_STEP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      pos_x     <= '0;
      pos_y     <= '0;
      ty_q      <= '0;
      mode_q    <= '0;
      blink_cnt <= '0;
      visible   <= 1'b0;
      frame_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      done    <= 1'b0;
      if (hide) begin
        state   <= IDLE;
        visible <= 1'b0;
        busy    <= 1'b0;
      end else if (start) begin
        mode_q    <= mode;
        ty_q      <= target_y;
        pos_x     <= target_x;
        blink_cnt <= '0;
        visible   <= 1'b1;
        if (mode == 2'b10) begin
          pos_y <= 10'(SLIDE_START_Y);
          state <= SLIDE;
          busy  <= 1'b1;
        end else begin
          pos_y <= target_y;
          state <= SHOW;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (tick) begin
        case (state)
          SLIDE: begin
            if ({1'b0, pos_y} <= slide_lim) begin
              pos_y <= ty_q;
              state <= SHOW;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pos_y <= pos_y - 10'(SLIDE_STEP);
            end
          end
          SHOW: begin
            if (mode_q == 2'b01) begin
              if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                visible   <= ~visible;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Hit test in 11 bits so pos+size never wraps; anything past the screen
  // edge simply never matches DrawX/DrawY.
  logic [10:0]       x_end, y_end, dx;
  logic [ADDR_W-1:0] dy;
  logic              in_x, in_y, hit, pix;
  logic [LOGO_W-1:0] row_sh;

  assign x_end = {1'b0, pos_x} + 11'(LOGO_W);
  assign y_end = {1'b0, pos_y} + 11'(LOGO_H);
  assign in_x  = (DrawX >= pos_x) && ({1'b0, DrawX} < x_end);
  assign in_y  = (DrawY >= pos_y) && ({1'b0, DrawY} < y_end);
  assign hit   = in_x & in_y;
  assign dx    = {1'b0, DrawX} - {1'b0, pos_x};
  assign dy    = ADDR_W'({1'b0, DrawY} - {1'b0, pos_y});
  assign rom_addr = hit ? dy : '0;

  // Shifting the row left by dx brings column dx to the MSB, which avoids an
  // out-of-range bit select when the pixel is outside the box.
  assign row_sh = rom_data << dx;
  assign pix    = row_sh[LOGO_W-1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) is_logo <= 1'b0;
    else          is_logo <= hit & visible & (state != IDLE) & pix;
  end

endmodule
